// File: rtl/main_mux_pkg.sv
// rtl/main_mux_pkg.sv - shared width default and select encodings for main_mux
package main_mux_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] SEL_A0 = 2'b00;
    localparam logic [1:0] SEL_A1 = 2'b01;
    localparam logic [1:0] SEL_A2 = 2'b10;
    localparam logic [1:0] SEL_A3 = 2'b11;

    // SEL1 is the MSB of the select index.
    function automatic logic [1:0] pack_sel(input logic sel1, input logic sel2);
        return {sel1, sel2};
    endfunction

endpackage

// File: rtl/main_mux_mux4.sv
// rtl/main_mux_mux4.sv - combinational 4:1 selector used by main_mux
module mux4
    import main_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // A case (not a ?: tree) keeps unknowns on unselected inputs out of y.
    always_comb begin
        y = '0;
        unique case (sel)
            SEL_A0: y = d0;
            SEL_A1: y = d1;
            SEL_A2: y = d2;
            SEL_A3: y = d3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/main_mux.sv
// rtl/main_mux.sv - 4:1 data selector with a single captured output register stage
module main_mux
    import main_mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] A2,
    input  logic [WIDTH-1:0] A3,
    input  logic             SEL1,
    input  logic             SEL2,
    input  logic             in_valid,
    output logic [WIDTH-1:0] C,
    output logic             out_valid,
    output logic [1:0]       out_sel
);

    logic [1:0]       sel;
    logic [WIDTH-1:0] sel_data;

    assign sel = pack_sel(SEL1, SEL2);

    mux4 #(
        .WIDTH (WIDTH)
    ) u_mux4 (
        .d0  (A0),
        .d1  (A1),
        .d2  (A2),
        .d3  (A3),
        .sel (sel),
        .y   (sel_data)
    );

    // Reset wins over a coincident capture; C/out_sel hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            C         <= '0;
            out_sel   <= SEL_A0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                C       <= sel_data;
                out_sel <= sel;
            end
        end
    end

endmodule

// File: tb/tb_main_mux.sv
// tb/tb_main_mux.sv - vector table, corner sequences and randomized model check for main_mux
module tb_main_mux;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] A0, A1, A2, A3;
    logic         SEL1, SEL2, in_valid;
    logic [W-1:0] C;
    logic         out_valid;
    logic [1:0]   out_sel;

    int n_checks = 0;
    int n_fail   = 0;

    main_mux #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .A0        (A0),
        .A1        (A1),
        .A2        (A2),
        .A3        (A3),
        .SEL1      (SEL1),
        .SEL2      (SEL2),
        .in_valid  (in_valid),
        .C         (C),
        .out_valid (out_valid),
        .out_sel   (out_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         iv;
        logic [1:0]   sel;
        logic [W-1:0] a0, a1, a2, a3;
        logic [W-1:0] exp_c;
        logic [1:0]   exp_sel;
        logic         exp_valid;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic iv, input logic [1:0] s,
                                input logic [W-1:0] a0, input logic [W-1:0] a1,
                                input logic [W-1:0] a2, input logic [W-1:0] a3,
                                input logic [W-1:0] ec, input logic [1:0] es,
                                input logic ev);
        vec_t v;
        v.rst = r; v.iv = iv; v.sel = s;
        v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
        v.exp_c = ec; v.exp_sel = es; v.exp_valid = ev;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic iv, input logic [1:0] s,
                         input logic [W-1:0] a0, input logic [W-1:0] a1,
                         input logic [W-1:0] a2, input logic [W-1:0] a3);
        @(negedge clk);
        rst = r; in_valid = iv; SEL1 = s[1]; SEL2 = s[0];
        A0 = a0; A1 = a1; A2 = a2; A3 = a3;
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] m_c;
    logic [1:0]   m_sel;
    logic         m_valid;
    logic [W-1:0] a [4];

    initial begin
        rst = 1'b1; in_valid = 1'b0; SEL1 = 1'b0; SEL2 = 1'b0;
        A0 = '0; A1 = '0; A2 = '0; A3 = '0;

        vecs.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 2'b11, 2, 3, 2, 3, 3, 2'b11, 1));
        vecs.push_back(mk(0, 1, 2'b10, 2, 3, 2, 3, 2, 2'b10, 1));
        vecs.push_back(mk(0, 1, 2'b01, 2, 3, 2, 3, 3, 2'b01, 1));
        vecs.push_back(mk(0, 1, 2'b00, 2, 3, 2, 3, 2, 2'b00, 1));
        vecs.push_back(mk(0, 1, 2'b00, 32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFFFF, 32'h11111111, 2'b00, 1));
        vecs.push_back(mk(0, 1, 2'b01, 32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFFFF, 32'h22222222, 2'b01, 1));
        vecs.push_back(mk(0, 1, 2'b10, 32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFFFF, 32'h33333333, 2'b10, 1));
        vecs.push_back(mk(0, 1, 2'b11, 32'h11111111, 32'h22222222, 32'h33333333, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 1));
        vecs.push_back(mk(0, 1, 2'b11, 2, 3, 2, 3, 3, 2'b11, 1));
        vecs.push_back(mk(0, 0, 2'b00, 2, 3, 2, 3, 3, 2'b11, 0));
        vecs.push_back(mk(0, 0, 2'b10, 2, 3, 2, 3, 3, 2'b11, 0));
        vecs.push_back(mk(0, 0, 2'b01, 2, 3, 2, 3, 3, 2'b11, 0));
        vecs.push_back(mk(1, 1, 2'b11, 2, 3, 2, 3, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 2'b01, 2, 3, 2, 3, 3, 2'b01, 1));
        vecs.push_back(mk(1, 0, 2'b10, 2, 3, 2, 3, 0, 2'b00, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].a3);
            check($sformatf("vec%0d C", i), C, vecs[i].exp_c);
            check($sformatf("vec%0d out_sel", i), {30'b0, out_sel}, {30'b0, vecs[i].exp_sel});
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
        end

        // Unknowns on the unselected inputs must not reach C.
        drive(0, 1, 2'b10, 'x, 'x, 2, 'x);
        check("xprop C", C, 2);
        check("xprop no_x", {31'b0, $isunknown(C)}, 0);
        check("xprop out_sel", {30'b0, out_sel}, 2);

        // Mid-stream reset, then first capture after release.
        drive(0, 1, 2'b11, 5, 6, 7, 8);
        drive(1, 1, 2'b01, 5, 6, 7, 8);
        check("midrst C", C, 0);
        check("midrst out_valid", {31'b0, out_valid}, 0);
        drive(0, 1, 2'b01, 5, 6, 7, 8);
        check("postrst C", C, 6);
        check("postrst out_valid", {31'b0, out_valid}, 1);

        m_c = 6; m_sel = 2'b01; m_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic         r, iv;
            logic [1:0]   s;
            r  = ($urandom_range(0, 15) == 0);
            iv = $urandom_range(0, 3) != 0;
            s  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) a[k] = $urandom;
            drive(r, iv, s, a[0], a[1], a[2], a[3]);
            if (r) begin
                m_c = 0; m_sel = 0; m_valid = 0;
            end else if (iv) begin
                m_c = a[s]; m_sel = s; m_valid = 1;
            end else begin
                m_valid = 0;
            end
            check($sformatf("rnd%0d C", n), C, m_c);
            check($sformatf("rnd%0d out_sel", n), {30'b0, out_sel}, {30'b0, m_sel});
            check($sformatf("rnd%0d out_valid", n), {31'b0, out_valid}, {31'b0, m_valid});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
